// File: rtl/vec_ldst_seq_pkg.sv
// Shared sizes, op encoding and FSM states for the vector load/store sequencer.
package vec_pkg;
   localparam int LANES   = 16;
   localparam int LANE_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int VREG_AW = 3;
   localparam int VREG_W  = LANES * LANE_W;
   localparam int IDX_W   = 4;

   localparam logic OP_LD = 1'b0;
   localparam logic OP_ST = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_LOAD_WB = 3'd2,
      S_ST_CAP  = 3'd3,
      S_STORE   = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   // Element idx occupies bits [idx*16 +: 16]; element 0 is the least significant lane.
   function automatic logic [LANE_W-1:0] lane_get(input logic [VREG_W-1:0] vec,
                                                  input logic [IDX_W-1:0]  idx);
      return vec[{idx, 4'h0} +: LANE_W];
   endfunction
endpackage

// File: rtl/vec_ldst_seq_if.sv
// Data-memory port of the vector load/store sequencer; master = sequencer, slave = memory.
interface vec_ldst_seq_if;
   import vec_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LANE_W-1:0] mem_wr_data;
   logic              mem_ack;
   logic [LANE_W-1:0] mem_rd_data;

   modport master (output mem_req, mem_we, mem_addr, mem_wr_data,
                   input  mem_ack, mem_rd_data);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wr_data,
                   output mem_ack, mem_rd_data);
endinterface

// File: rtl/vec_ldst_seq_addr_gen.sv
// Element address generator: latches base/stride on accept, steps idx on every accepted access.
module vec_addr_gen
   import vec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic [ADDR_W-1:0] base_in,
   input  logic [ADDR_W-1:0] stride_in,
   input  logic              adv,
   output logic [IDX_W-1:0]  idx,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   always_comb begin
      base_d   = base_q;
      stride_d = stride_q;
      idx_d    = idx_q;
      if (init) begin
         base_d   = base_in;
         stride_d = stride_in;
         idx_d    = 4'd0;
      end else if (adv) begin
         idx_d = idx_q + 4'd1;
      end else begin
         idx_d = idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q   <= 16'd0;
         stride_q <= 16'd0;
         idx_q    <= 4'd0;
      end else begin
         base_q   <= base_d;
         stride_q <= stride_d;
         idx_q    <= idx_d;
      end
   end

   // Product and sum are both kept to ADDR_W bits, so addresses wrap past 0xFFFF.
   assign addr = base_q + ({{(ADDR_W-IDX_W){1'b0}}, idx_q} * stride_q);
   assign idx  = idx_q;
   assign last = adv && (idx_q == 4'd15);
endmodule

// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer between issue, the VRF ports and the 16-bit data memory.
// Optional VEC_STRIDE_EN adds a stride input; otherwise elements are contiguous.
module vec_ldst_seq
   import vec_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               op,
   input  logic [VREG_AW-1:0] vreg,
   input  logic [ADDR_W-1:0]  base,
`ifdef VEC_STRIDE_EN
   input  logic [ADDR_W-1:0]  stride,
`endif
   output logic               busy,
   output logic               done,
   vec_ldst_seq_if.master     mem,
   output logic [VREG_AW-1:0] vrf_rd_addr,
   input  logic [VREG_W-1:0]  vrf_rd_data,
   output logic               vrf_wr_en,
   output logic [VREG_AW-1:0] vrf_wr_dst,
   output logic [VREG_W-1:0]  vrf_wr_data
);
   state_e             state_q, state_d;
   logic [VREG_W-1:0]  vbuf_q, vbuf_d;
   logic [VREG_AW-1:0] vreg_q, vreg_d;
   logic [VREG_AW-1:0] vrf_rd_addr_q, vrf_rd_addr_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic               vrf_wr_en_q, vrf_wr_en_d;

   logic               accept_s, adv_s, last_s;
   logic [IDX_W-1:0]   idx_s;
   logic [ADDR_W-1:0]  addr_s, stride_s;

`ifdef VEC_STRIDE_EN
   assign stride_s = stride;
`else
   assign stride_s = 16'd1;
`endif

   assign accept_s = (state_q == S_IDLE) && start;
   assign adv_s    = mem_req_q && mem.mem_ack;

   vec_addr_gen u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .init      (accept_s),
      .base_in   (base),
      .stride_in (stride_s),
      .adv       (adv_s),
      .idx       (idx_s),
      .addr      (addr_s),
      .last      (last_s)
   );

   // Next state and data path; outputs are then decoded from the next state so they register cleanly.
   always_comb begin
      state_d = state_q;
      vbuf_d  = vbuf_q;
      vreg_d  = vreg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               vreg_d  = vreg;
               state_d = (op == OP_ST) ? S_ST_CAP : S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (adv_s) begin
               vbuf_d[{idx_s, 4'h0} +: LANE_W] = mem.mem_rd_data;
               state_d = last_s ? S_LOAD_WB : S_LOAD;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LOAD_WB: state_d = S_DONE;
         S_ST_CAP: begin
            vbuf_d  = vrf_rd_data;
            state_d = S_STORE;
         end
         S_STORE: begin
            if (adv_s && last_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_STORE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      mem_req_d     = (state_d == S_LOAD) || (state_d == S_STORE);
      mem_we_d      = (state_d == S_STORE);
      vrf_wr_en_d   = (state_d == S_LOAD_WB);
      vrf_rd_addr_d = (state_d == S_ST_CAP) ? vreg_d : 3'd0;
   end

   // Single state/output register bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         vbuf_q        <= {VREG_W{1'b0}};
         vreg_q        <= 3'd0;
         vrf_rd_addr_q <= 3'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         vrf_wr_en_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         vbuf_q        <= vbuf_d;
         vreg_q        <= vreg_d;
         vrf_rd_addr_q <= vrf_rd_addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         vrf_wr_en_q   <= vrf_wr_en_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign mem.mem_req     = mem_req_q;
   assign mem.mem_we      = mem_we_q;
   assign mem.mem_addr    = mem_req_q ? addr_s : {ADDR_W{1'b0}};
   assign mem.mem_wr_data = mem_we_q ? lane_get(vbuf_q, idx_s) : {LANE_W{1'b0}};
   assign vrf_rd_addr     = vrf_rd_addr_q;
   assign vrf_wr_en       = vrf_wr_en_q;
   assign vrf_wr_dst      = vrf_wr_en_q ? vreg_q : 3'd0;
   assign vrf_wr_data     = vrf_wr_en_q ? vbuf_q : {VREG_W{1'b0}};
endmodule

// File: doc/vec_ldst_seq.md
Name: vec_ldst_seq

Overview:
Sequencer that moves whole vectors between the 8-entry x 256-bit vector register file and the 16-bit-word data memory. A vector load reads 16 memory words, assembles them and writes one VRF entry. A vector store reads one VRF entry and writes 16 memory words. Sits between the decode/issue stage and the VRF write port and data-memory port, and holds the pipeline off via busy while it runs.

Parameters:
LANES, 16, elements per vector
LANE_W, 16, bits per element and per memory word
ADDR_W, 16, memory address width
VREG_AW, 3, VRF index width (8 registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request a transfer; sampled only in IDLE
op  in  1  0 = load (mem->VRF), 1 = store (VRF->mem)
vreg  in  3  VRF register index
base  in  16  memory address of element 0
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
mem_req  out  1  memory access request, held until mem_ack
mem_we  out  1  1 = write access, valid with mem_req
mem_addr  out  16  element address
mem_wr_data  out  16  store element
mem_ack  in  1  access accepted; read data valid this same cycle
mem_rd_data  in  16  load element
vrf_rd_addr  out  3  VRF read index; the VRF read is combinational
vrf_rd_data  in  256  VRF read data
vrf_wr_en  out  1  VRF write strobe
vrf_wr_dst  out  3  VRF write index
vrf_wr_data  out  256  assembled vector

Behaviour:
- Reset (async, immediate) forces state IDLE, clears the element index, the vector buffer and the latched op/vreg/base, and drives every output to 0.
- Reset mid-transfer: no VRF write occurs and the transfer is abandoned. A partial store may leave memory partially written.
- States: IDLE, LOAD, LOAD_WB, ST_CAP, STORE, DONE.
- IDLE: if start=1, latch op, vreg and base, clear idx, and go to LOAD (op=0) or ST_CAP (op=1). Start outside IDLE is ignored; busy=0 means the next start is accepted.
- LOAD: mem_req=1, mem_we=0. On mem_ack, buf[idx*16 +: 16] <= mem_rd_data and idx increments. On the ack with idx=15, go to LOAD_WB.
- LOAD_WB: vrf_wr_en=1, vrf_wr_dst=vreg, vrf_wr_data=buf, for exactly one cycle, then go to DONE.
- ST_CAP: vrf_rd_addr=vreg and buf <= vrf_rd_data, for one cycle, then go to STORE.
- STORE: mem_req=1, mem_we=1, mem_wr_data=buf[idx*16 +: 16]. On mem_ack, idx increments. On the ack with idx=15, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE.
- mem_addr = base + idx*stride, truncated mod 2^16, so addresses wrap past 0xFFFF without error.
- Element 0 maps to vector bits [15:0] and element 15 to bits [255:240].
- While mem_ack=0, mem_req, mem_we, mem_addr and mem_wr_data hold stable. Stalls may be of any length.
- Latency with mem_ack tied high: start accepted at edge 0; LOAD/STORE occupies cycles 1-16 (load) or 2-17 (store); done in cycle 18 for both ops.
- vrf_wr_en is never asserted outside LOAD_WB. Outputs are 0 in states where they are unused.

Optional Feature:
Macro VEC_STRIDE_EN.
- Defined: adds input port stride (16 bits), latched with base at start; element address = base + idx*stride mod 2^16. Stride 0 is legal: all elements use the same address.
- Undefined: no stride port; stride is constant 1.

Decomposition:
- Package vec_pkg holds LANES, LANE_W, VREG_W = 256, VREG_AW, the op encoding (OP_LD = 0, OP_ST = 1) and the state enumeration.
- One sub-module, vec_addr_gen: holds the latched base/stride and the 4-bit idx, and outputs mem_addr and a last flag (idx == 15 on ack).

Test Plan:
- Load, ack tied high: vreg=3, base=0x0100, memory word[a] = a -> mem_addr 0x0100..0x010F over cycles 1-16; vrf_wr_en for 1 cycle in cycle 17 with dst 3 and data {0x010F,...,0x0100}; done in cycle 18.
- Store: VRF reg 5 = elements 0xA000+i, base=0x2000 -> 16 writes, mem[0x2000+i] = 0xA000+i; vrf_wr_en never high; done in cycle 18.
- Random mem_ack stalls of 0-5 cycles during load -> address and control held stable while waiting; final vector correct; done after the 16th ack + 2 cycles.
- Wrap-around: base=0xFFFA load -> addresses 0xFFFA..0xFFFF, then 0x0000..0x0009.
- start pulsed while busy, and start/op changing mid-transfer -> ignored; the single transfer completes unchanged.
- Reset asserted in cycle 8 of a load -> outputs 0 immediately, no vrf_wr_en; a new start after reset completes normally. With VEC_STRIDE_EN: stride=4, base=0 -> addresses 0,4,...,60.
